bcd_sevenseg_scanner: RTL and testbench

//  Consumes packed BCD digits ({Tens,Ones} for the default 2 digits) from the decimal-to-BCD stage.

---
 rtl/sevenseg_pkg.sv | 37 +++
 rtl/bcd_to_seg7.sv | 11 +
 rtl/bcd_sevenseg_scanner.sv | 112 +++++++++++
 tb/tb_bcd_sevenseg_scanner.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared 7-segment constants and the BCD-to-segment decode function.
// Patterns are active-high, ordered {a,b,c,d,e,f,g} with a in bit 6.
package sevenseg_pkg;

   localparam logic [6:0] SEG_0    = 7'h7E;
   localparam logic [6:0] SEG_1    = 7'h30;
   localparam logic [6:0] SEG_2    = 7'h6D;
   localparam logic [6:0] SEG_3    = 7'h79;
   localparam logic [6:0] SEG_4    = 7'h33;
   localparam logic [6:0] SEG_5    = 7'h5B;
   localparam logic [6:0] SEG_6    = 7'h5F;
   localparam logic [6:0] SEG_7    = 7'h70;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h7B;
   localparam logic [6:0] SEG_DASH = 7'h01;
   localparam logic [6:0] SEG_OFF  = 7'h00;

   // Non-decimal codes show a dash so a bad upstream value is visible.
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_DASH;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-high 7-segment pattern.
module bcd_to_seg7
   import sevenseg_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   assign seg = bcd_to_seg(digit);

endmodule

// File: rtl/bcd_sevenseg_scanner.sv
// Multiplexed 7-segment scanner: double-buffered BCD value, per-slot dead
// time, leading-zero blanking, registered pin outputs.
module bcd_sevenseg_scanner
   import sevenseg_pkg::*;
#(
   parameter int NUM_DIGITS   = 2,
   parameter int REFRESH_DIV  = 50000,
   parameter int DEAD_CYCLES  = 4,
   parameter bit COMMON_ANODE = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] bcd,
   input  logic                    load,
   input  logic                    blank,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int PW = $clog2(REFRESH_DIV);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PW-1:0] LAST_P = PW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0] DEAD_P = PW'(DEAD_CYCLES);
   localparam logic [IW-1:0] LAST_D = IW'(NUM_DIGITS - 1);
   // XOR masks turn the active-high internal view into pin polarity.
   localparam logic [6:0]            SEG_MASK = {7{COMMON_ANODE}};
   localparam logic [NUM_DIGITS-1:0] AN_MASK  = {NUM_DIGITS{COMMON_ANODE}};

   logic [PW-1:0]           prescaler;
   logic [IW-1:0]           digit_idx;
   logic [4*NUM_DIGITS-1:0] shadow;
   logic [4*NUM_DIGITS-1:0] active;
   logic                    slot_end;
   logic                    frame_end;
   logic [3:0]              cur_digit;
   logic [6:0]              seg_raw;
   logic [NUM_DIGITS-1:0]   an_raw;
   logic [NUM_DIGITS-1:0]   lz;

   assign slot_end  = (prescaler == LAST_P);
   assign frame_end = slot_end && (digit_idx == LAST_D);

   // Slot timer and digit counter; the last slot's end wraps to digit 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         prescaler <= '0;
         digit_idx <= '0;
      end else if (slot_end) begin
         prescaler <= '0;
         digit_idx <= (digit_idx == LAST_D) ? '0 : digit_idx + 1'b1;
      end else begin
         prescaler <= prescaler + 1'b1;
      end
   end

   // Double buffer: shadow takes loads anytime, active only at frame wrap,
   // so a frame never mixes old and new digits.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow     <= '0;
         active     <= '0;
         frame_done <= 1'b0;
      end else begin
         if (load)
            shadow <= bcd;
         if (frame_end)
            active <= shadow;
         frame_done <= frame_end;
      end
   end

   // Select the scanned digit and work out leading-zero blanking top-down.
   always_comb begin
      logic higher_zero;
      cur_digit   = active[3:0];
      lz          = '0;
      higher_zero = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (digit_idx == IW'(i))
            cur_digit = active[4*i +: 4];
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         higher_zero = higher_zero && (active[4*i +: 4] == 4'd0);
         lz[i]       = higher_zero;
      end
   end

   // One-hot enable outside the dead window unless blanked.
   always_comb begin
      an_raw = '0;
      for (int i = 0; i < NUM_DIGITS; i++)
         an_raw[i] = (digit_idx == IW'(i)) && (prescaler >= DEAD_P) &&
                     !blank && !lz[i];
   end

   bcd_to_seg7 u_dec (
      .digit (cur_digit),
      .seg   (seg_raw)
   );

   // Pin registers; seg carries the pattern even while enables are off.
   always_ff @(posedge clk) begin
      if (rst) begin
         seg <= SEG_OFF ^ SEG_MASK;
         an  <= AN_MASK;
      end else begin
         seg <= seg_raw ^ SEG_MASK;
         an  <= an_raw ^ AN_MASK;
      end
   end

endmodule

// File: tb/tb_bcd_sevenseg_scanner.sv
// Directed bench for bcd_sevenseg_scanner: table of display values plus
// hand sequences for boundary load, mid-frame reset and blanking.
module tb_bcd_sevenseg_scanner;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load = 1'b0;
   logic       blank = 1'b0;
   logic       blank2 = 1'b0;
   logic [7:0] bcd = 8'h00;
   logic [6:0] seg, seg2;
   logic [1:0] an, an2;
   logic       fd, fd2;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] v;
      logic [6:0] ones;
      logic [6:0] tens;
      logic       tens_on;
   } vec_t;

   vec_t tbl[5];

   bcd_sevenseg_scanner #(.NUM_DIGITS(2), .REFRESH_DIV(8), .DEAD_CYCLES(2),
                          .COMMON_ANODE(1'b0)) dut (
      .clk(clk), .rst(rst), .bcd(bcd), .load(load), .blank(blank),
      .seg(seg), .an(an), .frame_done(fd));

   bcd_sevenseg_scanner #(.NUM_DIGITS(2), .REFRESH_DIV(8), .DEAD_CYCLES(2),
                          .COMMON_ANODE(1'b1)) dut2 (
      .clk(clk), .rst(rst), .bcd(bcd), .load(load), .blank(blank2),
      .seg(seg2), .an(an2), .frame_done(fd2));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic load_val(input logic [7:0] v);
      bcd  = v;
      load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   task automatic wait_fd();
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick();
         if (fd === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL wait_frame_done: got no pulse, expected one within 40 cycles");
      end
   endtask

   // Called at the sample point right after a frame starts (p=0, digit 0).
   task automatic check_frame(input string nm, input logic [6:0] ones,
                              input logic [6:0] tens, input logic tens_on);
      for (int j = 1; j <= 16; j++) begin
         int slot, pos;
         logic [6:0] es;
         logic [1:0] ea;
         tick();
         slot = (j - 1) / 8;
         pos  = (j - 1) % 8;
         es   = (slot == 1) ? tens : ones;
         if (pos < 2)        ea = 2'b00;
         else if (slot == 1) ea = tens_on ? 2'b10 : 2'b00;
         else                ea = 2'b01;
         chk($sformatf("%s seg j=%0d", nm, j), 32'(seg), 32'(es));
         chk($sformatf("%s an j=%0d", nm, j), 32'(an), 32'(ea));
         chk($sformatf("%s frame_done j=%0d", nm, j), 32'(fd), 32'(j == 16));
      end
   endtask

   initial begin
      tbl[0] = '{8'h47, 7'h70, 7'h33, 1'b1};
      tbl[1] = '{8'h05, 7'h5B, 7'h7E, 1'b0};
      tbl[2] = '{8'h00, 7'h7E, 7'h7E, 1'b0};
      tbl[3] = '{8'hA3, 7'h79, 7'h01, 1'b1};
      tbl[4] = '{8'h90, 7'h7E, 7'h7B, 1'b1};

      // reset state
      tick();
      tick();
      chk("rst seg", 32'(seg), 32'h00);
      chk("rst an", 32'(an), 32'h0);
      chk("rst frame_done", 32'(fd), 32'h0);
      chk("rst seg ca", 32'(seg2), 32'h7F);
      chk("rst an ca", 32'(an2), 32'h3);
      chk("rst prescaler", 32'(dut.prescaler), 32'h0);
      chk("rst digit_idx", 32'(dut.digit_idx), 32'h0);
      rst = 1'b0;

      // table: load, let it reach the next frame boundary, check a full frame
      for (int k = 0; k < 5; k++) begin
         load_val(tbl[k].v);
         wait_fd();
         check_frame($sformatf("vec%0d", k), tbl[k].ones, tbl[k].tens, tbl[k].tens_on);
      end

      // load captured on the frame-boundary edge: old value one more frame
      repeat (15) tick();
      chk("pre-boundary prescaler", 32'(dut.prescaler), 32'h7);
      chk("pre-boundary digit_idx", 32'(dut.digit_idx), 32'h1);
      load_val(8'h12);
      chk("boundary frame_done", 32'(fd), 32'h1);
      check_frame("boundary old", 7'h7E, 7'h7B, 1'b1);
      check_frame("boundary new", 7'h6D, 7'h30, 1'b1);

      // mid-slot reset with a load pending in the same cycle
      repeat (13) tick();
      chk("mid prescaler", 32'(dut.prescaler), 32'h5);
      chk("mid digit_idx", 32'(dut.digit_idx), 32'h1);
      rst  = 1'b1;
      load = 1'b1;
      bcd  = 8'h88;
      tick();
      rst  = 1'b0;
      load = 1'b0;
      chk("mrst prescaler", 32'(dut.prescaler), 32'h0);
      chk("mrst digit_idx", 32'(dut.digit_idx), 32'h0);
      chk("mrst seg", 32'(seg), 32'h00);
      chk("mrst an", 32'(an), 32'h0);
      chk("mrst frame_done", 32'(fd), 32'h0);
      chk("mrst seg ca", 32'(seg2), 32'h7F);
      chk("mrst an ca", 32'(an2), 32'h3);
      check_frame("post-rst f1", 7'h7E, 7'h7E, 1'b0);
      check_frame("post-rst f2", 7'h7E, 7'h7E, 1'b0);

      // blank on the common-anode instance: enables off, scan keeps running
      blank2 = 1'b1;
      for (int j = 1; j <= 20; j++) begin
         tick();
         chk($sformatf("blank an ca j=%0d", j), 32'(an2), 32'h3);
         chk($sformatf("blank frame_done ca j=%0d", j), 32'(fd2), 32'(j == 16));
      end
      blank2 = 1'b0;
      tick();
      chk("unblank an ca", 32'(an2), 32'h2);
      chk("unblank seg ca", 32'(seg2), 32'h01);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule
